// File: rtl/reg_file_param_pkg.sv
// Shared constants and helpers for the datapath register file.
package reg_file_param_pkg;

  localparam int RF_WIDTH = 16;
  localparam int RF_DEPTH = 8;

  // Minimum address width able to select n registers (never below 1).
  function automatic int rf_clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    for (int i = 0; i < 32; i++) begin
      if (v > 0) begin
        r = r + 1;
        v = v >> 1;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int RF_AW = rf_clog2(RF_DEPTH);

  typedef logic [RF_WIDTH-1:0] rf_word_t;

endpackage

// File: rtl/reg_file_param_if.sv
// Register-file access bundle: one write port, two read ports, error flag.
interface reg_file_param_if
  import reg_file_param_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int AW    = RF_AW
);

  logic [AW-1:0]    read1_addr;
  logic [AW-1:0]    read2_addr;
  logic [AW-1:0]    write_addr;
  logic [WIDTH-1:0] write_data;
  logic             write_en;
  logic [WIDTH-1:0] read1_data;
  logic [WIDTH-1:0] read2_data;
  logic             err;

  // Pipeline side: decode/writeback stages drive addresses and write data.
  modport master (
    output read1_addr, read2_addr, write_addr, write_data, write_en,
    input  read1_data, read2_data, err
  );

  // Register-file side.
  modport slave (
    input  read1_addr, read2_addr, write_addr, write_data, write_en,
    output read1_data, read2_data, err
  );

endinterface

// File: rtl/reg_file_param_reg_nbit.sv
// WIDTH-bit enabled register with synchronous clear; holds when not enabled.
module reg_nbit #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_out
);

  logic [WIDTH-1:0] r_q;

  // Clear wins over load; otherwise load on enable, else hold.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_in;
    end
  end

  assign o_out = r_q;

endmodule

// File: rtl/reg_file_param.sv
// Architectural register file: DEPTH x WIDTH, one synchronous write port,
// two combinational read ports, optional write-to-read bypass and a
// one-cycle out-of-range address error flag.
module reg_file_param
  import reg_file_param_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int DEPTH  = RF_DEPTH,
  parameter int AW     = rf_clog2(DEPTH),
  parameter int BYPASS = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  reg_file_param_if.slave  bus
);

  if (WIDTH < 1 || DEPTH < 2 || (2 ** AW) < DEPTH || BYPASS < 0 || BYPASS > 1) begin : g_bad_params
    $error("reg_file_param: illegal WIDTH/DEPTH/AW/BYPASS combination");
  end

  // DEPTH held one bit wider than an address so the range compare is exact
  // even when DEPTH == 2**AW.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [AW-1:0]    w_rd1_addr;
  logic [AW-1:0]    w_rd2_addr;
  logic [AW-1:0]    w_wr_addr;
  logic [WIDTH-1:0] w_wr_data;
  logic             w_we;

  logic             w_wr_in_range;
  logic             w_wr_valid;
  logic             w_rd1_oob;
  logic             w_rd2_oob;
  logic             w_x_err;
  logic             w_err_next;

  logic [DEPTH-1:0] w_wr_sel;
  logic [WIDTH-1:0] w_regs [DEPTH];
  logic [WIDTH-1:0] w_rd1_data;
  logic [WIDTH-1:0] w_rd2_data;

  logic             r_err;

  assign w_rd1_addr = bus.read1_addr;
  assign w_rd2_addr = bus.read2_addr;
  assign w_wr_addr  = bus.write_addr;
  assign w_wr_data  = bus.write_data;
  assign w_we       = bus.write_en;

  assign w_wr_in_range = ({1'b0, w_wr_addr} < DEPTH_W);
  assign w_wr_valid    = w_we && w_wr_in_range;
  assign w_rd1_oob     = !({1'b0, w_rd1_addr} < DEPTH_W);
  assign w_rd2_oob     = !({1'b0, w_rd2_addr} < DEPTH_W);

  // Unknown control/address values only exist in simulation; this term is
  // constant 0 in hardware and merely flags a bad driver while simulating.
  assign w_x_err = ((^{w_rd1_addr, w_rd2_addr, w_we}) === 1'bx)
                || ((w_we === 1'b1) && ((^w_wr_addr) === 1'bx));

  assign w_err_next = w_rd1_oob || w_rd2_oob || (w_we && !w_wr_in_range) || w_x_err;

  // One enabled register per entry; an out-of-range write matches no
  // select line, so it is dropped without any extra gating.
  for (genvar g = 0; g < DEPTH; g++) begin : g_regs
    assign w_wr_sel[g] = w_we && (w_wr_addr == AW'(g));

    reg_nbit #(
      .WIDTH (WIDTH)
    ) u_reg (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (w_wr_sel[g]),
      .i_in  (w_wr_data),
      .o_out (w_regs[g])
    );
  end

  // Read muxes: unmatched (out-of-range) addresses fall through to zero;
  // with bypass enabled a same-cycle write to the selected entry overrides.
  always_comb begin
    w_rd1_data = '0;
    w_rd2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_rd1_addr == AW'(i)) begin
        w_rd1_data = w_regs[i];
      end
      if (w_rd2_addr == AW'(i)) begin
        w_rd2_data = w_regs[i];
      end
    end
    if (BYPASS == 1 && w_wr_valid && (w_rd1_addr == w_wr_addr)) begin
      w_rd1_data = w_wr_data;
    end
    if (BYPASS == 1 && w_wr_valid && (w_rd2_addr == w_wr_addr)) begin
      w_rd2_data = w_wr_data;
    end
  end

  // Error flag reflects only the previous cycle's addresses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_next;
    end
  end

  assign bus.read1_data = w_rd1_data;
  assign bus.read2_data = w_rd2_data;
  assign bus.err        = r_err;

endmodule
